// File: rtl/mem_copy_engine_if.sv
// Bundle of the core-facing control/status signals and the data-memory port
// driven by mem_copy_engine (master) and served by the core/memory side (slave).
interface mem_copy_engine_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) ();
    logic              start;
    logic [ADDR_W-1:0] src_addr;
    logic [ADDR_W-1:0] dst_addr;
    logic [ADDR_W-1:0] length;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] bytes_copied;
    logic [ADDR_W-1:0] mem_address;
    logic [DATA_W-1:0] mem_write_data;
    logic              mem_read;
    logic              mem_write;
    logic [DATA_W-1:0] mem_read_data;

    modport master (
        input  start, src_addr, dst_addr, length, mem_read_data,
        output busy, done, bytes_copied, mem_address, mem_write_data, mem_read, mem_write
    );

    modport slave (
        output start, src_addr, dst_addr, length, mem_read_data,
        input  busy, done, bytes_copied, mem_address, mem_write_data, mem_read, mem_write
    );
endinterface

// File: rtl/mem_copy_engine.sv
// Byte-serial forward block copier that owns the data-memory port while busy.
// Each byte costs RD_LAT read cycles plus one write cycle.
module mem_copy_engine #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8,
    parameter int RD_LAT = 1
) (
    input  logic               clk,
    input  logic               rst,
    mem_copy_engine_if.master  bus
);
    localparam int LAT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(RD_LAT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t            state_r;
    logic [ADDR_W-1:0] src_ptr_r;
    logic [ADDR_W-1:0] dst_ptr_r;
    logic [ADDR_W-1:0] remaining_r;
    logic [DATA_W-1:0] buffer_r;
    logic [LAT_W-1:0]  lat_cnt_r;
    logic              busy_r;
    logic              done_r;
    logic              mem_read_r;
    logic              mem_write_r;
    logic [ADDR_W-1:0] mem_address_r;
    logic [ADDR_W-1:0] bytes_copied_r;

    // Every output is a register that already reflects the state being entered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r        <= IDLE;
            src_ptr_r      <= '0;
            dst_ptr_r      <= '0;
            remaining_r    <= '0;
            buffer_r       <= '0;
            lat_cnt_r      <= '0;
            busy_r         <= 1'b0;
            done_r         <= 1'b0;
            mem_read_r     <= 1'b0;
            mem_write_r    <= 1'b0;
            mem_address_r  <= '0;
            bytes_copied_r <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    done_r <= 1'b0;
                    if (bus.start) begin
                        src_ptr_r      <= bus.src_addr;
                        dst_ptr_r      <= bus.dst_addr;
                        remaining_r    <= bus.length;
                        bytes_copied_r <= '0;
                        lat_cnt_r      <= '0;
                        if (bus.length == '0) begin
                            state_r <= DONE;
                            done_r  <= 1'b1;
                        end else begin
                            state_r       <= RD;
                            busy_r        <= 1'b1;
                            mem_read_r    <= 1'b1;
                            mem_address_r <= bus.src_addr;
                        end
                    end else begin
                        state_r <= IDLE;
                    end
                end
                RD: begin
                    if (lat_cnt_r == LAT_LAST) begin
                        buffer_r      <= bus.mem_read_data;
                        state_r       <= WR;
                        mem_read_r    <= 1'b0;
                        mem_write_r   <= 1'b1;
                        mem_address_r <= dst_ptr_r;
                    end else begin
                        lat_cnt_r <= lat_cnt_r + LAT_W'(1);
                    end
                end
                WR: begin
                    src_ptr_r      <= src_ptr_r + ADDR_W'(1);
                    dst_ptr_r      <= dst_ptr_r + ADDR_W'(1);
                    bytes_copied_r <= bytes_copied_r + ADDR_W'(1);
                    remaining_r    <= remaining_r - ADDR_W'(1);
                    mem_write_r    <= 1'b0;
                    lat_cnt_r      <= '0;
                    if (remaining_r == ADDR_W'(1)) begin
                        state_r <= DONE;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                    end else begin
                        state_r       <= RD;
                        mem_read_r    <= 1'b1;
                        mem_address_r <= src_ptr_r + ADDR_W'(1);
                    end
                end
                DONE: begin
                    state_r <= IDLE;
                    done_r  <= 1'b0;
                end
                default: begin
                    state_r     <= IDLE;
                    busy_r      <= 1'b0;
                    done_r      <= 1'b0;
                    mem_read_r  <= 1'b0;
                    mem_write_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy           = busy_r;
    assign bus.done           = done_r;
    assign bus.mem_read       = mem_read_r;
    assign bus.mem_write      = mem_write_r;
    assign bus.mem_address    = mem_address_r;
    assign bus.mem_write_data = buffer_r;
    assign bus.bytes_copied   = bytes_copied_r;
endmodule

// File: tb/tb_mem_copy_engine.sv
// Directed bench for mem_copy_engine: one instance with RD_LAT=1, one with RD_LAT=2,
// sharing a 256x8 memory model.
module tb_mem_copy_engine;
    logic       clk = 1'b0;
    logic       rst;
    logic       go;
    logic       sel;
    logic [7:0] src;
    logic [7:0] dst;
    logic [7:0] len;

    always #5 clk = ~clk;

    mem_copy_engine_if #(.ADDR_W(8), .DATA_W(8)) if1 ();
    mem_copy_engine_if #(.ADDR_W(8), .DATA_W(8)) if2 ();

    assign if1.start    = go & ~sel;
    assign if2.start    = go & sel;
    assign if1.src_addr = src;
    assign if2.src_addr = src;
    assign if1.dst_addr = dst;
    assign if2.dst_addr = dst;
    assign if1.length   = len;
    assign if2.length   = len;

    mem_copy_engine #(.ADDR_W(8), .DATA_W(8), .RD_LAT(1)) dut1 (.clk(clk), .rst(rst), .bus(if1.master));
    mem_copy_engine #(.ADDR_W(8), .DATA_W(8), .RD_LAT(2)) dut2 (.clk(clk), .rst(rst), .bus(if2.master));

    logic [7:0] mem [0:255];
    logic       init_req;
    logic       poke_req;
    logic [7:0] poke_addr;
    logic [7:0] poke_data;

    function automatic logic [7:0] pat(input int i);
        if (i < 16)       return 8'(i);
        else if (i == 16) return 8'h00;
        else if (i < 32)  return 8'(272 - i);
        else              return 8'h00;
    endfunction

    // Memory model: synchronous writes, combinational reads while mem_read is high.
    always @(posedge clk) begin
        if (init_req) begin
            for (int i = 0; i < 256; i++) mem[i] <= pat(i);
        end else begin
            if (poke_req)      mem[poke_addr]        <= poke_data;
            if (if1.mem_write) mem[if1.mem_address]  <= if1.mem_write_data;
            if (if2.mem_write) mem[if2.mem_address]  <= if2.mem_write_data;
        end
    end

    assign if1.mem_read_data = if1.mem_read ? mem[if1.mem_address] : 8'h00;
    assign if2.mem_read_data = if2.mem_read ? mem[if2.mem_address] : 8'h00;

    logic       s_busy, s_done, s_read, s_write;
    logic [7:0] s_addr, s_bc;
    assign s_busy  = sel ? if2.busy         : if1.busy;
    assign s_done  = sel ? if2.done         : if1.done;
    assign s_read  = sel ? if2.mem_read     : if1.mem_read;
    assign s_write = sel ? if2.mem_write    : if1.mem_write;
    assign s_addr  = sel ? if2.mem_address  : if1.mem_address;
    assign s_bc    = sel ? if2.bytes_copied : if1.bytes_copied;

    int n_assert = 0;
    int n_fail   = 0;
    int done_cyc, rd_cycles, rd_rises, wr_cycles, alt_err, excl_err, done_busy;
    logic [7:0] rd_log [0:15];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic init_mem();
        @(negedge clk); init_req = 1'b1;
        @(negedge clk); init_req = 1'b0;
    endtask

    task automatic poke(input logic [7:0] a, input logic [7:0] d);
        @(negedge clk); poke_req = 1'b1; poke_addr = a; poke_data = d;
        @(negedge clk); poke_req = 1'b0;
    endtask

    // Launch one job and trace the port until done (bounded); cycle 1 follows the start edge.
    task automatic run_job(input logic sel_i, input logic [7:0] s, input logic [7:0] d,
                           input logic [7:0] l, input int pulse_cyc);
        int   last;
        logic prev_rd;
        sel = sel_i;
        done_cyc = -1; rd_cycles = 0; rd_rises = 0; wr_cycles = 0;
        alt_err = 0; excl_err = 0; done_busy = -1; last = 0; prev_rd = 1'b0;
        @(negedge clk); src = s; dst = d; len = l; go = 1'b1;
        @(posedge clk);
        for (int cyc = 1; cyc <= 300; cyc++) begin
            @(negedge clk);
            go  = (cyc == pulse_cyc);
            src = 8'hC3; dst = 8'h3C; len = 8'h55;
            if (s_read && s_write) excl_err++;
            if ((s_read || s_write) && !s_busy) excl_err++;
            if (s_read && !prev_rd) begin
                if (rd_rises < 16) rd_log[4'(rd_rises)] = s_addr;
                rd_rises++;
                if (last == 1) alt_err++;
                last = 1;
            end
            if (s_read) rd_cycles++;
            if (s_write) begin
                wr_cycles++;
                if (last != 1) alt_err++;
                last = 2;
            end
            prev_rd = s_read;
            if (s_done) begin
                done_cyc  = cyc;
                done_busy = int'(s_busy);
                break;
            end
        end
        go = 1'b0;
    endtask

    initial begin
        int idle_act;
        rst = 1'b1; go = 1'b0; sel = 1'b0; src = 8'h00; dst = 8'h00; len = 8'h00;
        init_req = 1'b0; poke_req = 1'b0; poke_addr = 8'h00; poke_data = 8'h00;
        init_mem();
        chk("reset_dut1", {4'h0, if1.busy, if1.done, if1.mem_read, if1.mem_write,
            if1.mem_address, if1.mem_write_data, if1.bytes_copied}, 32'h0);
        chk("reset_dut2", {4'h0, if2.busy, if2.done, if2.mem_read, if2.mem_write,
            if2.mem_address, if2.mem_write_data, if2.bytes_copied}, 32'h0);
        @(negedge clk); rst = 1'b0;

        // Basic copy, RD_LAT=1
        init_mem();
        run_job(1'b0, 8'd0, 8'd20, 8'd4, 0);
        chk("basic_done_cycle", done_cyc, 32'd9);
        chk("basic_read_cycles", rd_cycles, 32'd4);
        chk("basic_write_cycles", wr_cycles, 32'd4);
        chk("basic_alternation", alt_err, 32'd0);
        chk("basic_exclusive", excl_err, 32'd0);
        chk("basic_busy_at_done", done_busy, 32'd0);
        chk("basic_bytes_copied", s_bc, 32'd4);
        chk("basic_mem20_23", {mem[20], mem[21], mem[22], mem[23]}, 32'h00010203);
        @(negedge clk);
        chk("basic_done_one_cycle", s_done, 32'd0);
        chk("basic_bytes_hold", s_bc, 32'd4);

        // Zero length
        init_mem();
        run_job(1'b0, 8'd5, 8'd6, 8'd0, 0);
        chk("zero_done_cycle", done_cyc, 32'd1);
        chk("zero_strobes", rd_cycles + wr_cycles, 32'd0);
        chk("zero_bytes_copied", s_bc, 32'd0);
        chk("zero_mem6", mem[6], 32'h06);

        // Overlap replication
        init_mem();
        run_job(1'b0, 8'd1, 8'd2, 8'd3, 0);
        chk("overlap_done_cycle", done_cyc, 32'd7);
        chk("overlap_mem2_4", {mem[2], mem[3], mem[4]}, 32'h010101);

        // Address wrap
        init_mem();
        poke(8'd255, 8'hAA);
        run_job(1'b0, 8'd255, 8'd8, 8'd2, 0);
        chk("wrap_done_cycle", done_cyc, 32'd5);
        chk("wrap_read_addrs", {rd_log[0], rd_log[1]}, 32'hFF00);
        chk("wrap_mem8_9", {mem[8], mem[9]}, 32'hAA00);

        // Reset mid-job after the third WR edge
        init_mem();
        sel = 1'b0;
        @(negedge clk); src = 8'd0; dst = 8'd24; len = 8'd8; go = 1'b1;
        @(posedge clk);
        @(negedge clk); go = 1'b0;
        repeat (6) @(negedge clk);
        chk("abort_pre_reset_read", if1.mem_read, 32'd1);
        chk("abort_pre_reset_count", if1.bytes_copied, 32'd3);
        rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        chk("abort_outputs_zero", {4'h0, if1.busy, if1.done, if1.mem_read, if1.mem_write,
            if1.mem_address, if1.mem_write_data, if1.bytes_copied}, 32'h0);
        chk("abort_mem24_26", {mem[24], mem[25], mem[26]}, 32'h000102);
        chk("abort_mem27_30", {mem[27], mem[28], mem[29], mem[30]}, 32'hF5F4F3F2);
        chk("abort_mem31", mem[31], 32'hF1);
        run_job(1'b0, 8'd0, 8'd24, 8'd8, 0);
        chk("rerun_done_cycle", done_cyc, 32'd17);
        chk("rerun_bytes_copied", s_bc, 32'd8);
        chk("rerun_mem24_27", {mem[24], mem[25], mem[26], mem[27]}, 32'h00010203);
        chk("rerun_mem28_31", {mem[28], mem[29], mem[30], mem[31]}, 32'h04050607);

        // RD_LAT=2 with start pulsed mid-job
        init_mem();
        run_job(1'b1, 8'd0, 8'd20, 8'd2, 3);
        chk("lat2_done_cycle", done_cyc, 32'd7);
        chk("lat2_read_cycles", rd_cycles, 32'd4);
        chk("lat2_read_bursts", rd_rises, 32'd2);
        chk("lat2_write_cycles", wr_cycles, 32'd2);
        chk("lat2_alternation", alt_err, 32'd0);
        chk("lat2_mem20_21", {mem[20], mem[21]}, 32'h0001);
        idle_act = 0;
        repeat (4) begin
            @(negedge clk);
            if (s_busy || s_read || s_write || s_done) idle_act++;
        end
        chk("lat2_single_job", idle_act, 32'd0);
        chk("lat2_bytes_hold", s_bc, 32'd2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
